// File: rtl/lfsr_chk_pkg.sv
// rtl/lfsr_chk_pkg.sv - shared checker state encoding and LFSR feedback helper
package lfsr_chk_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam int MAX_N = 64;

  // Fibonacci feedback of an n-bit register (taps n-1 and 0), zero-extended to MAX_N.
  function automatic logic lfsr_fb(input logic [MAX_N-1:0] sr, input int n);
    return sr[n-1] ^ sr[0];
  endfunction

endpackage

// File: rtl/lfsr_chk_predict.sv
// rtl/lfsr_chk_predict.sv - predictor shift register, loads either the received bit or its own prediction
module lfsr_chk_predict
  import lfsr_chk_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         load_pred,
  input  logic         bit_in,
  output logic [N-1:0] sr,
  output logic         pred
);

  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;
  logic         in_bit;

  always_comb begin
    pred   = lfsr_fb(MAX_N'(sr_q), N);
    in_bit = load_pred ? pred : bit_in;
    sr_d   = sr_q;
    if (shift_en) begin
      sr_d = {sr_q[N-2:0], in_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr = sr_q;

endmodule

// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - self-seeding LFSR stream checker with lock and error reporting
// Define LFSR_CHK_FLYWHEEL_EN to let the predictor free-run on its own prediction while LOCKED.
module lfsr_seq_checker
  import lfsr_chk_pkg::*;
#(
  parameter int n          = 4,
  parameter int VERIFY_LEN = 8,
  parameter int LOSS_THR   = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             bit_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [n-1:0]     state_out
);

  localparam int SEED_W  = $clog2(n + 1);
  localparam int MATCH_W = $clog2(VERIFY_LEN + 1);
  localparam int MISS_W  = $clog2(LOSS_THR + 1);

  chk_state_e         state_q, state_d;
  logic [SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic [n-1:0]       sr;
  logic [n-1:0]       sr_rx;
  logic               pred;
  logic               load_pred;

`ifdef LFSR_CHK_FLYWHEEL_EN
  assign load_pred = (state_q == LOCKED);
`else
  assign load_pred = 1'b0;
`endif

  lfsr_chk_predict #(
    .N (n)
  ) u_predict (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (ena),
    .load_pred (load_pred),
    .bit_in    (bit_in),
    .sr        (sr),
    .pred      (pred)
  );

  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    sr_rx       = {sr[n-2:0], bit_in};

    if (ena) begin
      case (state_q)
        SEED: begin
          if (seed_cnt_q == SEED_W'(n - 1)) begin
            // An all-zero seed is the LFSR lock-up state; keep gathering.
            seed_cnt_d = '0;
            if (sr_rx != '0) begin
              state_d     = VERIFY;
              match_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end
        VERIFY: begin
          if (bit_in == pred) begin
            if (match_cnt_q == MATCH_W'(VERIFY_LEN - 1)) begin
              state_d     = LOCKED;
              locked_d    = 1'b1;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            // The offending bit is already in the register as the first new seed bit.
            state_d     = SEED;
            seed_cnt_d  = SEED_W'(1);
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (bit_in != pred) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (miss_cnt_q == MISS_W'(LOSS_THR - 1)) begin
              state_d    = SEED;
              locked_d   = 1'b0;
              miss_cnt_d = '0;
              seed_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: begin
          state_d  = SEED;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state_out = sr;

endmodule
